// File: rtl/rv32i_types.sv
// Shared types for the mp_pipeline core: data-memory responder state,
// default data-memory base address and a byte-lane masking helper.
package rv32i_types;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_t;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1eceb000;

  // Keep byte lane i of w when m[i] is set, otherwise zero it.
  function automatic logic [31:0] mask_bytes(input logic [31:0] w, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = m[i] ? w[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised data-memory storage: one synchronous byte-enabled write
// port and one combinational read port sampled by the owner at acceptance.
module dmem_bank #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       be_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  // Contents are intentionally not reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the dmem request/response interface: fixed-latency replies,
// range checking and a sticky protocol error flag.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int          LATENCY     = 2,
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err,
  output dmem_state_t dbg_state_o
);

  // Handshake: a request is any cycle with a nonzero mask; it is accepted
  // when IDLE or in the response cycle, dropped (and flagged) otherwise.
  // dmem_resp is a single-cycle pulse LATENCY cycles after acceptance.

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        rd_req, wr_req, req, both;
  logic        resp, accept, drop, in_range;
  logic [31:0] off, word_off, bank_rdata;

  assign rd_req = |dmem_rmask;
  assign wr_req = |dmem_wmask;
  assign req    = rd_req | wr_req;
  assign both   = rd_req & wr_req;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the compare.
  assign off      = dmem_addr - BASE_ADDR;
  assign word_off = off >> 2;
  assign in_range = word_off < 32'(DEPTH_WORDS);

  assign resp   = (state_q == WAIT) && (cnt_q == 4'd0);
  assign accept = req && ((state_q == IDLE) || resp);
  assign drop   = req && !accept;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk    (clk),
    .we_i   (accept && wr_req && in_range),
    .idx_i  (word_off[IDX_W-1:0]),
    .be_i   (dmem_wmask),
    .wdata_i(dmem_wdata),
    .rdata_o(bank_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = WAIT;
      cnt_d   = CNT_LOAD;
      if (rd_req && !wr_req) begin
        rdata_d = in_range ? mask_bytes(bank_rdata, dmem_rmask) : 32'h0;
      end
      if (both || !in_range) err_d = 1'b1;
    end else if (state_q == WAIT) begin
      if (cnt_q == 4'd0) state_d = IDLE;
      else               cnt_d   = cnt_q - 4'd1;
    end
    if (drop) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem_resp   = resp;
  assign dmem_rdata  = rdata_q;
  assign dmem_err    = err_q;
  assign dbg_state_o = state_q;

endmodule
